multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Multi-cycle signed 32-bit multiply/divide unit that sits beside the ALU in the execute stage of the 5-stage pipeline.
- The X stage pulses a start control with both operands. The unit iterates for a fixed number of cycles, then returns the result with a one-cycle ready strobe.
- The pipeline's hazard logic stalls F/D/X while busy is high, then writes the result into the X/M latch on data_resultRDY.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration count equals WIDTH.

Ports:
- clock  input  1  master clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs.
- data_operandA  input  WIDTH  multiplicand / dividend; sampled only on the start edge.
- data_operandB  input  WIDTH  multiplier / divisor; sampled only on the start edge.
- ctrl_MULT  input  1  single-cycle start pulse for a signed multiply.
- ctrl_DIV  input  1  single-cycle start pulse for a signed divide.
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient; registered and held until the next completion.
- data_exception  output  1  overflow or divide-by-zero flag; registered and held with data_result.
- data_resultRDY  output  1  high for exactly one cycle when data_result is new.
- busy  output  1  high from the start edge until the cycle in which data_resultRDY is high (inclusive).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; counter, operand and accumulator registers cleared.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- States:
  - IDLE to MUL on ctrl_MULT.
  - IDLE to DIV on ctrl_DIV.
  - MUL to DONE and DIV to DONE when counter reaches WIDTH.
  - DONE to IDLE unconditionally.
- Start edge T0:
  - Latch A and B into internal registers; counter=0.
  - Later changes on the operand inputs have no effect on the operation.
- Simultaneous ctrl_MULT and ctrl_DIV: MULT wins; DIV is ignored.
- Start while busy (MUL, DIV or DONE):
  - Abort the current operation and restart with the new operands at that edge.
  - No ready strobe is produced for the aborted operation.
- MUL:
  - Radix-2 Booth shift-add over WIDTH iterations; one iteration per edge, T1..T32.
  - 2*WIDTH-bit signed product.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff the product's upper WIDTH+1 bits are not all equal (signed overflow).
- DIV:
  - Restoring or non-restoring division on magnitudes over WIDTH iterations; signs fixed up at the end.
  - Quotient truncates toward zero; the remainder is discarded.
  - Divisor==0: data_result=0, data_exception=1.
  - Dividend==-2^(WIDTH-1) and divisor==-1: data_result=0x80000000, data_exception=1.
  - Otherwise data_exception=0.
- Latency:
  - On edge T0+WIDTH+1 (T33 for WIDTH=32), state enters DONE.
  - On that same edge, data_result and data_exception are updated and data_resultRDY goes to 1.
  - On edge T34, data_resultRDY returns to 0 and busy returns to 0.
- busy is 1 in every cycle between T0 and T34.
- data_result and data_exception are stable between completions; they are not cleared when data_resultRDY falls.
- A start pulse arriving in the DONE cycle is accepted as a new T0. The ready strobe for the finished operation is still seen for that one cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset, then ctrl_MULT with A=7, B=-6 -> data_resultRDY pulses once 33 cycles after the start edge; data_result=0xFFFFFFD6 (-42); data_exception=0; busy high for cycles 0..33.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1. Also A=0x7FFFFFFF, B=1 -> data_result=0x7FFFFFFF, data_exception=0.
- ctrl_DIV with A=-7, B=2 -> data_result=0xFFFFFFFD (-3), data_exception=0. A=100, B=0 -> data_result=0, data_exception=1. A=0x80000000, B=-1 -> data_result=0x80000000, data_exception=1.
- ctrl_DIV with A=50, B=5; at cycle 10 pulse ctrl_MULT with A=3, B=4 -> no strobe for the divide. A single strobe arrives 33 cycles after the second pulse with data_result=12.
- ctrl_MULT and ctrl_DIV together with A=9, B=3 -> data_result=27 (multiply wins). Operands changed to 1,1 one cycle after start do not alter the result.
- Start ctrl_MULT with A=5, B=5; assert reset at cycle 15 between clock edges -> outputs go to 0 immediately, with no strobe. After release, ctrl_DIV with A=20, B=4 -> data_result=5 after 33 cycles.

Source files
------------

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit for the execute stage.
// Multiply is radix-2 Booth over WIDTH iterations; divide is restoring
// division on magnitudes with a sign fix-up when the result is written.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   m_reg;      // multiplicand, or divisor magnitude
    logic [WIDTH-1:0]   q_reg;      // multiplier / product low half, or dividend / quotient
    logic [WIDTH:0]     acc;        // product high half (one guard bit), or partial remainder
    logic               q_m1;       // Booth look-behind bit
    logic               neg_q;
    logic               div_zero;
    logic               div_ovf;

    logic               iter_done;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign iter_done      = (count == CNT_W'(WIDTH));
    assign busy           = (state != S_IDLE);
    assign data_resultRDY = (state == S_DONE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state: any start pulse restarts the unit, multiply taking priority
    always_comb begin
        state_next = state;
        if (ctrl_MULT) begin
            state_next = S_MUL;
        end else if (ctrl_DIV) begin
            state_next = S_DIV;
        end else begin
            case (state)
                S_MUL, S_DIV: if (iter_done) state_next = S_DONE;
                S_DONE:       state_next = S_IDLE;
                default:      state_next = S_IDLE;
            endcase
        end
    end

    // One Booth step, one restoring-division step, and the final result forms
    always_comb begin
        booth_sum = acc;
        case ({q_reg[0], q_m1})
            2'b01:   booth_sum = acc + {m_reg[WIDTH-1], m_reg};
            2'b10:   booth_sum = acc - {m_reg[WIDTH-1], m_reg};
            default: booth_sum = acc;
        endcase
        rem_sh  = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, m_reg});
        rem_sub = rem_sh - {1'b0, m_reg};
        prod    = {acc[WIDTH-1:0], q_reg};
        mul_ovf = (|prod[2*WIDTH-1:WIDTH-1]) && !(&prod[2*WIDTH-1:WIDTH-1]);
        quot    = neg_q ? -q_reg : q_reg;
        abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    // Datapath: load operands on a start pulse, then iterate until the count reaches WIDTH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            m_reg    <= '0;
            q_reg    <= '0;
            acc      <= '0;
            q_m1     <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (ctrl_MULT) begin
            count    <= '0;
            m_reg    <= data_operandA;
            q_reg    <= data_operandB;
            acc      <= '0;
            q_m1     <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (ctrl_DIV) begin
            count    <= '0;
            m_reg    <= abs_b;
            q_reg    <= abs_a;
            acc      <= '0;
            q_m1     <= 1'b0;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
        end else if (state == S_MUL && !iter_done) begin
            count <= count + 1'b1;
            acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
            q_m1  <= q_reg[0];
        end else if (state == S_DIV && !iter_done) begin
            count <= count + 1'b1;
            acc   <= rem_ge ? rem_sub : rem_sh;
            q_reg <= {q_reg[WIDTH-2:0], rem_ge};
        end
    end

    // Result registers: written only on the edge that enters DONE, held otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (state_next == S_DONE) begin
            if (state == S_MUL) begin
                data_result    <= prod[WIDTH-1:0];
                data_exception <= mul_ovf;
            end else begin
                data_result    <= div_zero ? '0 : quot;
                data_exception <= div_zero | div_ovf;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard testbench for multdiv_unit: expected results are queued at each
// start pulse and compared when the ready strobe appears.
module tb_multdiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clock;
    logic         reset;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           cyc       = 0;
    int           busy_from = 0;
    int           busy_to   = -1;
    logic [W-1:0] last_res  = '0;
    logic         last_exc  = 1'b0;
    int           n_checks  = 0;
    int           n_pass    = 0;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Monitor: sample 1 time unit after each rising edge
    always @(posedge clock) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        check("busy", busy, (cyc >= busy_from && cyc <= busy_to));
        if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            check("rdy", data_resultRDY, 1'b1);
            check("result", data_result, e.res);
            check("exception", data_exception, e.exc);
            last_res = e.res;
            last_exc = e.exc;
        end else if (data_resultRDY) begin
            check("spurious_rdy", data_resultRDY, 1'b0);
        end
    end

    task automatic start_op(input bit do_mul, input bit do_div,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t    e;
        int      s;
        longint  pa, pb, p;
        int      ia, ib;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = do_mul;
        ctrl_DIV      = do_div;
        s = cyc + 1;
        for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].cyc >= s) sbq.delete(i);
        if (do_mul) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            e.res = p[31:0];
            e.exc = (p[63:31] != '0) && (p[63:31] != '1);
        end else begin
            ia = $signed(a);
            ib = $signed(b);
            if (ib == 0) begin
                e.res = '0;
                e.exc = 1'b1;
            end else if (ia == 32'sh8000_0000 && ib == -1) begin
                e.res = 32'h8000_0000;
                e.exc = 1'b1;
            end else begin
                e.res = ia / ib;
                e.exc = 1'b0;
            end
        end
        e.cyc = s + LAT;
        sbq.push_back(e);
        busy_from = s;
        busy_to   = s + LAT;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check("drain", (sbq.size() == 0 && !busy), 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_result", data_result, '0);
        check("reset_exc", data_exception, 1'b0);
        check("reset_rdy", data_resultRDY, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;

        // Basic multiplies
        start_op(1, 0, 32'd7, -32'sd6);
        wait_idle(60);
        start_op(1, 0, 32'h0001_0000, 32'h0001_0000);
        wait_idle(60);
        start_op(1, 0, 32'h7FFF_FFFF, 32'd1);
        wait_idle(60);

        // Divides including the two exception cases
        start_op(0, 1, -32'sd7, 32'd2);
        wait_idle(60);
        start_op(0, 1, 32'd100, 32'd0);
        wait_idle(60);
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(60);

        // Abort a divide with a multiply after ~10 cycles
        start_op(0, 1, 32'd50, 32'd5);
        repeat (9) @(negedge clock);
        start_op(1, 0, 32'd3, 32'd4);
        wait_idle(60);

        // Both starts together: multiply wins; operands scrambled after start
        start_op(1, 1, 32'd9, 32'd3);
        wait_idle(60);
        repeat (3) @(negedge clock);
        check("held_result", data_result, last_res);
        check("held_exc", data_exception, last_exc);

        // Start in the DONE cycle: previous strobe still seen
        start_op(1, 0, 32'd123, -32'sd45);
        repeat (32) @(negedge clock);
        start_op(0, 1, -32'sd1000, 32'd7);
        // Start on the completing edge: that operation is aborted
        repeat (31) @(negedge clock);
        start_op(1, 0, 32'h8000_0000, 32'h8000_0000);
        wait_idle(100);

        // Random operations
        for (int i = 0; i < 4; i++) begin
            start_op(1, 0, $urandom, $urandom);
            wait_idle(60);
            start_op(0, 1, $urandom, $urandom_range(1, 1000) * ((i % 2 == 0) ? 1 : -1));
            wait_idle(60);
        end

        // Asynchronous reset mid-operation
        start_op(1, 1, 32'd9, 32'd3);
        wait_idle(60);
        start_op(1, 0, 32'd5, 32'd5);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        sbq.delete();
        busy_to  = -1;
        last_res = '0;
        last_exc = 1'b0;
        #1;
        check("async_result", data_result, '0);
        check("async_exc", data_exception, 1'b0);
        check("async_rdy", data_resultRDY, 1'b0);
        check("async_busy", busy, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        start_op(0, 1, 32'd20, 32'd4);
        wait_idle(60);
        repeat (3) @(negedge clock);
        check("final_result", data_result, last_res);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
